// File: rtl/mem_stage_lsu_if.sv
// Purpose: groups the EX/MEM request, pipeline result and data-memory signals of the LSU.
// Latency: none (wires only).
// Backpressure: stall travels back to the pipeline; memory side has no flow control.
interface mem_stage_lsu_if;
    // pipeline request
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    // pipeline response
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        illegal;
    // word-addressed data memory
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    // pipeline + memory side
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  stall, load_valid, load_data, illegal,
        input  mem_we, mem_addr, mem_wd,
        output mem_rd
    );

    // LSU side
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output stall, load_valid, load_data, illegal,
        output mem_we, mem_addr, mem_wd,
        input  mem_rd
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// Purpose: RV32I byte-addressed load/store to word memory (RMW sub-word stores, split word-crossing accesses).
// Latency: aligned SW / in-word load 1 cycle, sub-word store or crossing load 2, crossing store 4; load result registered.
// Backpressure: stall held high on every cycle of a multi-cycle access except the last.
module mem_stage_lsu #(
    parameter int ADDR_WORDS       = 1024,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    mem_stage_lsu_if.slave bus
);

    localparam logic [31:0] AW = 32'(ADDR_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        ST_WR_LO,
        LD_HI,
        ST_RD_HI,
        ST_WR_HI
    } state_t;

    // Word index wraps modulo the memory depth.
    function automatic logic [31:0] wrap_idx(input logic [31:0] w);
        return w % AW;
    endfunction

    // Access size in bytes from funct3[1:0].
    function automatic logic [2:0] size_of(input logic [1:0] f);
        case (f)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Byte lanes touched by an access of the given size, before shifting by the offset.
    function automatic logic [63:0] lane_mask(input logic [2:0] size);
        case (size)
            3'd1:    return 64'h0000_0000_0000_00FF;
            3'd2:    return 64'h0000_0000_0000_FFFF;
            default: return 64'h0000_0000_FFFF_FFFF;
        endcase
    endfunction

    // Pull the addressed bytes down to bit 0 from the little-endian {hi, lo} pair.
    function automatic logic [31:0] align_load(input logic [31:0] hi, input logic [31:0] lo,
                                               input logic [1:0] off);
        case (off)
            2'd0:    return lo;
            2'd1:    return {hi[7:0],  lo[31:8]};
            2'd2:    return {hi[15:0], lo[31:16]};
            default: return {hi[23:0], lo[31:24]};
        endcase
    endfunction

    // Sign/zero extension by funct3; W passes through.
    function automatic logic [31:0] extend(input logic [31:0] r, input logic [2:0] f);
        case (f)
            3'b000:  return {{24{r[7]}}, r[7:0]};
            3'b001:  return {{16{r[15]}}, r[15:0]};
            3'b100:  return {24'h0, r[7:0]};
            3'b101:  return {16'h0, r[15:0]};
            default: return r;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] lo_word_q, lo_word_d;
    logic [31:0] hi_word_q, hi_word_d;
    logic        crossing_q, crossing_d;
    logic        load_valid_q, load_valid_d;
    logic [31:0] load_data_q, load_data_d;
    logic        illegal_q, illegal_d;

    logic        stall_c;
    logic        mem_we_c;
    logic [31:0] mem_addr_c;
    logic [31:0] mem_wd_c;

    logic [1:0]  req_off;
    logic [2:0]  req_size;
    logic        req_cross;
    logic        req_f3_ok;
    logic        req_bad;
    logic        req_aligned_sw;
    logic [31:0] req_lo_idx;
    logic [31:0] cap_lo_idx;
    logic [31:0] cap_hi_idx;
    logic [4:0]  st_shift;
    logic [63:0] st_mask;
    logic [63:0] st_data;
    logic [63:0] st_merged;

    // Decode of the incoming request: size, word crossing, legality and first word index.
    always_comb begin
        req_off        = bus.req_addr[1:0];
        req_size       = size_of(bus.req_funct3[1:0]);
        req_cross      = ({1'b0, req_off} + req_size) > 3'd4;
        req_f3_ok      = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                         (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                         (bus.req_funct3 == 3'b101);
        req_bad        = !req_f3_ok || (bus.req_we && bus.req_funct3[2]) ||
                         (req_cross && !ALLOW_MISALIGNED);
        req_aligned_sw = (req_off == 2'd0) && (bus.req_funct3[1:0] == 2'b10);
        req_lo_idx     = wrap_idx({2'b00, bus.req_addr[31:2]});
    end

    // Word indices and byte-merged store data for the captured access.
    always_comb begin
        cap_lo_idx = wrap_idx({2'b00, addr_q[31:2]});
        cap_hi_idx = wrap_idx(cap_lo_idx + 32'd1);
        st_shift   = {addr_q[1:0], 3'b000};
        st_mask    = lane_mask(size_of(funct3_q[1:0])) << st_shift;
        st_data    = {32'h0, wdata_q} << st_shift;
        st_merged  = ({hi_word_q, lo_word_q} & ~st_mask) | (st_data & st_mask);
    end

    // Next-state, capture and memory-port control for the access sequencer.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        wdata_d      = wdata_q;
        lo_word_d    = lo_word_q;
        hi_word_d    = hi_word_q;
        crossing_d   = crossing_q;
        load_valid_d = 1'b0;
        load_data_d  = load_data_q;
        illegal_d    = 1'b0;
        stall_c      = 1'b0;
        mem_we_c     = 1'b0;
        mem_addr_c   = cap_lo_idx;
        mem_wd_c     = st_merged[31:0];

        case (state_q)
            IDLE: begin
                mem_addr_c = req_lo_idx;
                mem_wd_c   = bus.req_wdata;
                if (bus.req_valid) begin
                    if (req_bad) begin
                        illegal_d = 1'b1;
                    end else if (!bus.req_we) begin
                        if (req_cross) begin
                            addr_d    = bus.req_addr;
                            funct3_d  = bus.req_funct3;
                            wdata_d   = bus.req_wdata;
                            lo_word_d = bus.mem_rd;
                            state_d   = LD_HI;
                            stall_c   = 1'b1;
                        end else begin
                            load_valid_d = 1'b1;
                            load_data_d  = extend(align_load(32'h0, bus.mem_rd, req_off),
                                                  bus.req_funct3);
                        end
                    end else if (req_aligned_sw) begin
                        mem_we_c = 1'b1;
                    end else begin
                        addr_d     = bus.req_addr;
                        funct3_d   = bus.req_funct3;
                        wdata_d    = bus.req_wdata;
                        lo_word_d  = bus.mem_rd;
                        crossing_d = req_cross;
                        state_d    = ST_WR_LO;
                        stall_c    = 1'b1;
                    end
                end
            end
            ST_WR_LO: begin
                mem_addr_c = cap_lo_idx;
                mem_we_c   = 1'b1;
                mem_wd_c   = st_merged[31:0];
                if (crossing_q) begin
                    state_d = ST_RD_HI;
                    stall_c = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ST_RD_HI: begin
                mem_addr_c = cap_hi_idx;
                hi_word_d  = bus.mem_rd;
                stall_c    = 1'b1;
                state_d    = ST_WR_HI;
            end
            ST_WR_HI: begin
                mem_addr_c = cap_hi_idx;
                mem_we_c   = 1'b1;
                mem_wd_c   = st_merged[63:32];
                state_d    = IDLE;
            end
            LD_HI: begin
                mem_addr_c   = cap_hi_idx;
                load_valid_d = 1'b1;
                load_data_d  = extend(align_load(bus.mem_rd, lo_word_q, addr_q[1:0]), funct3_q);
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset must never let a write or a stall escape, whatever the state.
        if (rst) begin
            mem_we_c = 1'b0;
            stall_c  = 1'b0;
        end
    end

    // State, captures and registered load/illegal results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= 32'h0;
            funct3_q     <= 3'h0;
            wdata_q      <= 32'h0;
            lo_word_q    <= 32'h0;
            hi_word_q    <= 32'h0;
            crossing_q   <= 1'b0;
            load_valid_q <= 1'b0;
            load_data_q  <= 32'h0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            wdata_q      <= wdata_d;
            lo_word_q    <= lo_word_d;
            hi_word_q    <= hi_word_d;
            crossing_q   <= crossing_d;
            load_valid_q <= load_valid_d;
            load_data_q  <= load_data_d;
            illegal_q    <= illegal_d;
        end
    end

    assign bus.stall      = stall_c;
    assign bus.load_valid = load_valid_q;
    assign bus.load_data  = load_data_q;
    assign bus.illegal    = illegal_q;
    assign bus.mem_we     = mem_we_c;
    assign bus.mem_addr   = mem_addr_c;
    assign bus.mem_wd     = mem_wd_c;

endmodule
